// File: rtl/ray_plane_setup.sv
// rtl/ray_plane_setup.sv - 3-stage numerator/denominator front end for ray/plane intersection
// Optional back-face culling: define PLANE_CULL_EN.
module ray_plane_setup #(
    parameter int Q_BITS   = 10,
    parameter int D_WIDTH  = 32,
    parameter int ID_WIDTH = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                valid_in,
    input  logic [ID_WIDTH-1:0] ray_id_in,
    input  logic [D_WIDTH-1:0]  org_x,
    input  logic [D_WIDTH-1:0]  org_y,
    input  logic [D_WIDTH-1:0]  org_z,
    input  logic [D_WIDTH-1:0]  dir_x,
    input  logic [D_WIDTH-1:0]  dir_y,
    input  logic [D_WIDTH-1:0]  dir_z,
    input  logic [D_WIDTH-1:0]  pnt_x,
    input  logic [D_WIDTH-1:0]  pnt_y,
    input  logic [D_WIDTH-1:0]  pnt_z,
    input  logic [D_WIDTH-1:0]  nrm_x,
    input  logic [D_WIDTH-1:0]  nrm_y,
    input  logic [D_WIDTH-1:0]  nrm_z,
    output logic [D_WIDTH-1:0]  dividend,
    output logic [D_WIDTH-1:0]  divisor,
    output logic                hit_ok,
    output logic [ID_WIDTH-1:0] ray_id_out,
    output logic                valid_out
);

    localparam int PW = 2*D_WIDTH + 1;
    localparam int SW = 2*D_WIDTH + 3;
    localparam logic signed [SW-1:0] SAT_MAX = {{(SW-D_WIDTH+1){1'b0}}, {(D_WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN = {{(SW-D_WIDTH+1){1'b1}}, {(D_WIDTH-1){1'b0}}};
    localparam logic [D_WIDTH-1:0]   ONE_Q   = {{(D_WIDTH-1){1'b0}}, 1'b1} << Q_BITS;

    logic [D_WIDTH-1:0]  w_org [3];
    logic [D_WIDTH-1:0]  w_dir [3];
    logic [D_WIDTH-1:0]  w_pnt [3];
    logic [D_WIDTH-1:0]  w_nrm [3];

    logic [D_WIDTH:0]    r_diff [3];
    logic [D_WIDTH-1:0]  r_nrm  [3];
    logic [D_WIDTH-1:0]  r_dir  [3];
    logic [PW-1:0]       r_pnum [3];
    logic [PW-1:0]       r_pden [3];
    logic [2:0]          r_valid;
    logic [ID_WIDTH-1:0] r_id1;
    logic [ID_WIDTH-1:0] r_id2;

    logic signed [SW-1:0] w_num_sum;
    logic signed [SW-1:0] w_den_sum;
    logic signed [SW-1:0] w_num_sh;
    logic signed [SW-1:0] w_den_sh;
    logic                 w_den_zero;
    logic                 w_hit;

    assign w_org = '{org_x, org_y, org_z};
    assign w_dir = '{dir_x, dir_y, dir_z};
    assign w_pnt = '{pnt_x, pnt_y, pnt_z};
    assign w_nrm = '{nrm_x, nrm_y, nrm_z};

    function automatic logic [SW-1:0] sext_prod(input logic [PW-1:0] p);
        return {{2{p[PW-1]}}, p};
    endfunction

    function automatic logic [D_WIDTH-1:0] saturate(input logic signed [SW-1:0] v);
        if (v > SAT_MAX)
            return SAT_MAX[D_WIDTH-1:0];
        else if (v < SAT_MIN)
            return SAT_MIN[D_WIDTH-1:0];
        else
            return v[D_WIDTH-1:0];
    endfunction

    // Operands are sign-extended to the full product width so the truncated
    // multiply is exact for signed values.
    always_ff @(posedge clock) begin
        for (int i = 0; i < 3; i++) begin
            r_diff[i] <= {w_pnt[i][D_WIDTH-1], w_pnt[i]} - {w_org[i][D_WIDTH-1], w_org[i]};
            r_nrm[i]  <= w_nrm[i];
            r_dir[i]  <= w_dir[i];
            r_pnum[i] <= {{(D_WIDTH+1){r_nrm[i][D_WIDTH-1]}}, r_nrm[i]}
                       * {{D_WIDTH{r_diff[i][D_WIDTH]}}, r_diff[i]};
            r_pden[i] <= {{(D_WIDTH+1){r_nrm[i][D_WIDTH-1]}}, r_nrm[i]}
                       * {{(D_WIDTH+1){r_dir[i][D_WIDTH-1]}}, r_dir[i]};
        end
    end

    always_comb begin
        w_num_sum  = sext_prod(r_pnum[0]) + sext_prod(r_pnum[1]) + sext_prod(r_pnum[2]);
        w_den_sum  = sext_prod(r_pden[0]) + sext_prod(r_pden[1]) + sext_prod(r_pden[2]);
        w_num_sh   = w_num_sum >>> Q_BITS;
        w_den_sh   = w_den_sum >>> Q_BITS;
        w_den_zero = (w_den_sh == '0);
`ifdef PLANE_CULL_EN
        w_hit      = w_den_sh[SW-1];
`else
        w_hit      = ~w_den_zero;
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid    <= '0;
            r_id1      <= '0;
            r_id2      <= '0;
            dividend   <= '0;
            divisor    <= '0;
            hit_ok     <= 1'b0;
            ray_id_out <= '0;
        end else begin
            r_valid    <= {r_valid[1:0], valid_in};
            r_id1      <= ray_id_in;
            r_id2      <= r_id1;
            dividend   <= saturate(w_num_sh);
            divisor    <= w_den_zero ? ONE_Q : saturate(w_den_sh);
            hit_ok     <= w_hit;
            ray_id_out <= r_id2;
        end
    end

    assign valid_out = r_valid[2];

endmodule

// File: tb/tb_ray_plane_setup.sv
// tb/tb_ray_plane_setup.sv - directed self-checking bench for ray_plane_setup
module tb_ray_plane_setup;
    localparam int DW = 32;
    localparam int IW = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          valid_in = 1'b0;
    logic [IW-1:0] ray_id_in = '0;
    logic [DW-1:0] org_x = '0, org_y = '0, org_z = '0;
    logic [DW-1:0] dir_x = '0, dir_y = '0, dir_z = '0;
    logic [DW-1:0] pnt_x = '0, pnt_y = '0, pnt_z = '0;
    logic [DW-1:0] nrm_x = '0, nrm_y = '0, nrm_z = '0;
    logic [DW-1:0] dividend, divisor;
    logic          hit_ok, valid_out;
    logic [IW-1:0] ray_id_out;

    int n_checks = 0;
    int n_errors = 0;

`ifdef PLANE_CULL_EN
    localparam logic CULL = 1'b1;
`else
    localparam logic CULL = 1'b0;
`endif

    ray_plane_setup #(.Q_BITS(10), .D_WIDTH(DW), .ID_WIDTH(IW)) dut (
        .clock(clock), .reset(reset), .valid_in(valid_in), .ray_id_in(ray_id_in),
        .org_x(org_x), .org_y(org_y), .org_z(org_z),
        .dir_x(dir_x), .dir_y(dir_y), .dir_z(dir_z),
        .pnt_x(pnt_x), .pnt_y(pnt_y), .pnt_z(pnt_z),
        .nrm_x(nrm_x), .nrm_y(nrm_y), .nrm_z(nrm_z),
        .dividend(dividend), .divisor(divisor), .hit_ok(hit_ok),
        .ray_id_out(ray_id_out), .valid_out(valid_out)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_ray(input logic [31:0] ox, oy, oz, dx, dy, dz,
                           input logic [31:0] px, py, pz, nx, ny, nz);
        org_x = ox; org_y = oy; org_z = oz;
        dir_x = dx; dir_y = dy; dir_z = dz;
        pnt_x = px; pnt_y = py; pnt_z = pz;
        nrm_x = nx; nrm_y = ny; nrm_z = nz;
    endtask

    task automatic fire(input string tag, input logic [IW-1:0] id,
                        input logic [31:0] exp_num, input logic [31:0] exp_den, input logic exp_hit);
        valid_in  = 1'b1;
        ray_id_in = id;
        tick();
        valid_in  = 1'b0;
        tick();
        check({tag, "_early_valid"}, valid_out, 0);
        tick();
        check({tag, "_valid"}, valid_out, 1);
        check({tag, "_dividend"}, dividend, exp_num);
        check({tag, "_divisor"}, divisor, exp_den);
        check({tag, "_hit"}, hit_ok, exp_hit);
        check({tag, "_id"}, ray_id_out, id);
    endtask

    bit sv[4]  = '{1, 1, 0, 1};
    int sid[4] = '{1, 2, 3, 4};

    initial begin
        #1 reset = 1'b1;
        #2;
        check("rst_valid", valid_out, 0);
        check("rst_dividend", dividend, 0);
        check("rst_divisor", divisor, 0);
        check("rst_hit", hit_ok, 0);
        check("rst_id", ray_id_out, 0);
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b0;

        // Q10 reals: 1.0 = 1024
        set_ray(0, 0, 0,  0, 0, 2048,  0, 0, 10240,  0, 0, 1024);
        fire("basic", 8'd5, 32'd10240, 32'd2048, ~CULL);

        set_ray(0, 0, 0,  0, 0, -2048,  0, 0, 10240,  0, 0, 1024);
        fire("negdir", 8'd6, 32'd10240, -32'd2048, 1'b1);

        set_ray(0, 0, 0,  1024, 0, 0,  0, 0, 4096,  0, 0, 1024);
        fire("parallel", 8'd7, 32'd4096, 32'd1024, 1'b0);

        // n=(1,2,3) p0-o=(3,4,5) d=(-1,0.5,-2): num 26, den -6
        set_ray(1024, 1024, 1024,  -1024, 512, -2048,  4096, 5120, 6144,  1024, 2048, 3072);
        fire("dot3", 8'd8, 32'd26624, -32'd6144, 1'b1);

        set_ray(32'h80000000, 0, 0,  0, 0, 0,  32'h7FFFFFFF, 0, 0,  32'h7FFFFFFF, 0, 0);
        fire("sat_pos", 8'd20, 32'h7FFFFFFF, 32'd1024, 1'b0);

        set_ray(32'h80000000, 0, 0,  0, 0, 0,  32'h7FFFFFFF, 0, 0,  32'h80000001, 0, 0);
        fire("sat_neg", 8'd21, 32'h80000000, 32'd1024, 1'b0);

        // raw product -1 floors to -1; raw +1 truncates to 0 and is parallel
        set_ray(0, 0, 0,  0, 0, -1,  0, 0, 0,  0, 0, 1);
        fire("floor_neg", 8'd22, 32'd0, 32'hFFFFFFFF, 1'b1);

        set_ray(0, 0, 0,  0, 0, 1,  0, 0, 0,  0, 0, 1);
        fire("floor_zero", 8'd23, 32'd0, 32'd1024, 1'b0);

        set_ray(0, 0, 0,  0, 0, 2048,  0, 0, 10240,  0, 0, 1024);
        for (int i = 0; i < 7; i++) begin
            if (i < 4) begin
                valid_in  = sv[i];
                ray_id_in = sid[i][IW-1:0];
            end else begin
                valid_in = 1'b0;
            end
            tick();
            if (i >= 2) begin
                automatic int  j = i - 2;
                automatic bit  ev = (j < 4) ? sv[j] : 1'b0;
                check($sformatf("stream_valid%0d", j), valid_out, ev);
                if (ev) begin
                    check($sformatf("stream_id%0d", j), ray_id_out, sid[j]);
                    check($sformatf("stream_num%0d", j), dividend, 32'd10240);
                end
            end
        end

        valid_in = 1'b1; ray_id_in = 8'd9;  tick();
        ray_id_in = 8'd10; tick();
        ray_id_in = 8'd11; tick();
        valid_in = 1'b0;
        check("pre_rst_valid", valid_out, 1);
        check("pre_rst_id", ray_id_out, 9);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_valid", valid_out, 0);
        check("mid_rst_dividend", dividend, 0);
        check("mid_rst_divisor", divisor, 0);
        check("mid_rst_hit", hit_ok, 0);
        check("mid_rst_id", ray_id_out, 0);
        @(posedge clock);
        #2 reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("drop_valid%0d", k), valid_out, 0);
        end
        fire("after_rst", 8'd12, 32'd10240, 32'd2048, ~CULL);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
